// File: rtl/echo_tof_gate.sv
`timescale 1ns/1ps
// echo_tof_gate
// Ultrasonic time-of-flight gate and counter. The transmit-modulation and
// echo inputs are synchronised. A rising edge on the transmit signal starts a
// measurement. The echo is ignored while the transducer rings down (BLANK).
// After that, the echo must stay asserted for MIN_ECHO cycles before it is
// accepted. The flight time is reported in CLK cycles, counted from the
// trigger edge to the echo rise. If no echo is accepted, a timeout is
// reported instead.
//
// Ports
//   CLK          system clock, all logic on posedge
//   RSTn         asynchronous active-low reset
//   enable       1 = measurements allowed, 0 aborts a measurement silently
//   pulse_t      transmit modulation (async), rising edge = trigger
//   pulse_r      echo receiver output (async), polarity set by ECHO_POL
//   test_count   high from the trigger edge until accept/timeout/abort
//   busy         FSM not in IDLE
//   tof_count    last accepted flight time, held until the next accept
//   tof_valid    1-cycle strobe, tof_count updated
//   tof_timeout  1-cycle strobe, no qualified echo before TIMEOUT_CYCLES
//   tof_overrun  1-cycle strobe, trigger seen while busy (trigger ignored)
module echo_tof_gate #(
    parameter int CNT_W          = 16,
    parameter int BLANK_CYCLES   = 100,
    parameter int MIN_ECHO       = 4,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int ECHO_POL       = 1
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             enable,
    input  logic             pulse_t,
    input  logic             pulse_r,
    output logic             test_count,
    output logic             busy,
    output logic [CNT_W-1:0] tof_count,
    output logic             tof_valid,
    output logic             tof_timeout,
    output logic             tof_overrun
);

    localparam int   QCNT_W  = $clog2(MIN_ECHO + 1);
    localparam logic POL_INV = (ECHO_POL == 0);

    typedef enum logic [1:0] {IDLE, BLANK, LISTEN, QUAL} state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cand_reg;
    logic [QCNT_W-1:0] qcnt_reg;

    // Bit 0 carries pulse_t, bit 1 carries pulse_r.
    logic [1:0] async_in;
    logic [1:0] sync_s2;
    logic [1:0] sync_s3;

    assign async_in = {pulse_r, pulse_t};

    // Each input gets two synchroniser flops (s1, s2) and one history flop (s3).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic [2:0] sh_reg;
            always_ff @(posedge CLK or negedge RSTn) begin
                if (!RSTn) begin
                    sh_reg <= '0;
                end else begin
                    sh_reg <= {sh_reg[1:0], async_in[gi]};
                end
            end
            assign sync_s2[gi] = sh_reg[1];
            assign sync_s3[gi] = sh_reg[2];
        end
    endgenerate

    logic t_rise;
    logic echo;
    logic echo_prev;
    logic e_rise;

    assign t_rise    = sync_s2[0] & ~sync_s3[0];
    assign echo      = sync_s2[1] ^ POL_INV;
    // The history flop keeps tracking during BLANK. An echo that is already
    // high when LISTEN starts therefore produces no rising edge.
    assign echo_prev = sync_s3[1] ^ POL_INV;
    assign e_rise    = echo & ~echo_prev;

    logic             accept_now;
    logic             timeout_now;
    logic [CNT_W-1:0] accept_val;
    logic [CNT_W-1:0] cnt_inc;

    // When MIN_ECHO is 1, the rise itself qualifies the echo. Otherwise the
    // echo is accepted on the last qualifying cycle in QUAL.
    assign accept_now  = ((state_reg == LISTEN) && e_rise && (MIN_ECHO == 1)) ||
                         ((state_reg == QUAL) && echo &&
                          (qcnt_reg == QCNT_W'(MIN_ECHO - 1)));
    assign accept_val  = (state_reg == LISTEN) ? cnt_reg : cand_reg;
    // If accept and timeout happen in the same cycle, the accept wins.
    assign timeout_now = ((state_reg == LISTEN) || (state_reg == QUAL)) &&
                         (cnt_reg == CNT_W'(TIMEOUT_CYCLES)) && !accept_now;
    assign cnt_inc     = (cnt_reg == CNT_W'(TIMEOUT_CYCLES)) ? cnt_reg
                                                              : cnt_reg + CNT_W'(1);

    assign busy = (state_reg != IDLE);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            cand_reg    <= '0;
            qcnt_reg    <= '0;
            test_count  <= 1'b0;
            tof_count   <= '0;
            tof_valid   <= 1'b0;
            tof_timeout <= 1'b0;
            tof_overrun <= 1'b0;
        end else begin
            tof_valid   <= 1'b0;
            tof_timeout <= 1'b0;
            tof_overrun <= 1'b0;
            if (state_reg == IDLE) begin
                if (t_rise && enable) begin
                    state_reg  <= BLANK;
                    cnt_reg    <= CNT_W'(1);
                    test_count <= 1'b1;
                end
            end else if (!enable) begin
                // Abort: return to IDLE with no strobes; tof_count is held.
                state_reg  <= IDLE;
                test_count <= 1'b0;
            end else begin
                // A trigger while busy is only flagged.
                // The running count is not restarted.
                if (t_rise) begin
                    tof_overrun <= 1'b1;
                end
                cnt_reg <= cnt_inc;
                if (accept_now) begin
                    tof_count  <= accept_val;
                    tof_valid  <= 1'b1;
                    test_count <= 1'b0;
                    state_reg  <= IDLE;
                end else if (timeout_now) begin
                    tof_timeout <= 1'b1;
                    test_count  <= 1'b0;
                    state_reg   <= IDLE;
                end else begin
                    case (state_reg)
                        BLANK: begin
                            if (cnt_reg == CNT_W'(BLANK_CYCLES)) begin
                                state_reg <= LISTEN;
                            end
                        end
                        LISTEN: begin
                            if (e_rise) begin
                                cand_reg  <= cnt_reg;
                                qcnt_reg  <= QCNT_W'(1);
                                state_reg <= QUAL;
                            end
                        end
                        QUAL: begin
                            // A drop-out is a glitch. The candidate is
                            // discarded and the count keeps running.
                            if (!echo) begin
                                state_reg <= LISTEN;
                            end else begin
                                qcnt_reg <= qcnt_reg + QCNT_W'(1);
                            end
                        end
                        default: state_reg <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_echo_tof_gate.sv
`timescale 1ns/1ps
// Testbench for echo_tof_gate.
// dut_a uses the default parameters.
// dut_b uses MIN_ECHO=1 and an active-low echo.
// Expected strobes go into a scoreboard queue.
// A monitor pops the queue and compares each strobe the DUTs present.
module tb_echo_tof_gate;

    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    logic pt[2];
    logic pr[2];
    logic en[2];
    logic tc[2];
    logic bz[2];
    logic vld[2];
    logic tmo[2];
    logic ovr[2];
    logic [15:0] tofc[2];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int tc_cnt[2] = '{0, 0};

    typedef struct {
        int dut;
        int kind;   // 0 valid, 1 timeout, 2 overrun
        int due;
        int val;
    } exp_t;
    exp_t sb[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    echo_tof_gate #(.CNT_W(16), .BLANK_CYCLES(100), .MIN_ECHO(4),
                    .TIMEOUT_CYCLES(5000), .ECHO_POL(1)) dut_a (
        .CLK(CLK), .RSTn(RSTn), .enable(en[0]), .pulse_t(pt[0]), .pulse_r(pr[0]),
        .test_count(tc[0]), .busy(bz[0]), .tof_count(tofc[0]),
        .tof_valid(vld[0]), .tof_timeout(tmo[0]), .tof_overrun(ovr[0]));

    echo_tof_gate #(.CNT_W(16), .BLANK_CYCLES(100), .MIN_ECHO(1),
                    .TIMEOUT_CYCLES(5000), .ECHO_POL(0)) dut_b (
        .CLK(CLK), .RSTn(RSTn), .enable(en[1]), .pulse_t(pt[1]), .pulse_r(pr[1]),
        .test_count(tc[1]), .busy(bz[1]), .tof_count(tofc[1]),
        .tof_valid(vld[1]), .tof_timeout(tmo[1]), .tof_overrun(ovr[1]));

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("PASS %s: %0d (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic mon_check(input int d, input int k);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe: dut%0d kind %0d at cycle %0d, required none", d, k, cyc);
        end else begin
            e = sb.pop_front();
            if (e.dut != d || e.kind != k || e.due != cyc || int'(tofc[d]) != e.val) begin
                errors++;
                $display("FAIL strobe: got dut%0d kind %0d cycle %0d tof %0d, required dut%0d kind %0d cycle %0d tof %0d",
                         d, k, cyc, tofc[d], e.dut, e.kind, e.due, e.val);
            end else begin
                $display("PASS strobe: dut%0d kind %0d cycle %0d tof %0d", d, k, cyc, tofc[d]);
            end
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge CLK);
            if (RSTn) begin
                for (int i = 0; i < 2; i++) begin
                    if (tc[i]) tc_cnt[i]++;
                    if (vld[i]) mon_check(i, 0);
                    if (tmo[i]) mon_check(i, 1);
                    if (ovr[i]) mon_check(i, 2);
                end
            end
        end
    endtask

    task automatic expect_ev(input int d, input int k, input int due, input int val);
        exp_t e;
        e.dut = d; e.kind = k; e.due = due; e.val = val;
        sb.push_back(e);
    endtask

    // Trigger pulse of 20 cycles; t is the cycle the rising edge was driven.
    task automatic trigger(input int d, output int t);
        t = cyc;
        pt[d] = 1'b1;
        step(20);
        pt[d] = 1'b0;
    endtask

    task automatic at(input int t, input int off);
        if (t + off > cyc) step(t + off - cyc);
    endtask

    task automatic set_echo(input int d, input logic active);
        pr[d] = (d == 0) ? active : ~active;
    endtask

    task automatic drained(input string name);
        chk(name, sb.size(), 0);
    endtask

    initial begin
        int t;
        int base;
        pt[0] = 1'b0; pt[1] = 1'b0;
        pr[0] = 1'b0; pr[1] = 1'b1;
        en[0] = 1'b1; en[1] = 1'b1;
        fork
            monitor_loop();
        join_none
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_tof_count", tofc[i], 0);
            chk("reset_test_count", tc[i], 0);
            chk("reset_busy", bz[i], 0);
            chk("reset_strobes", {vld[i], tmo[i], ovr[i]}, 0);
        end
        step(3);
        RSTn = 1'b1;
        step(5);

        // Echo rises at cnt 1000 and is held 10 cycles.
        base = tc_cnt[0];
        trigger(0, t);
        expect_ev(0, 0, t + 2 + 1000 + 4, 1000);
        at(t, 1000); set_echo(0, 1);
        at(t, 1010); set_echo(0, 0);
        at(t, 1015);
        chk("t1_test_count_cycles", tc_cnt[0] - base, 1003);
        drained("t1_drained");

        // Blanked pulse at 50..60, real echo at 600.
        trigger(0, t);
        expect_ev(0, 0, t + 606, 600);
        at(t, 50);  set_echo(0, 1);
        at(t, 60);  set_echo(0, 0);
        at(t, 600); set_echo(0, 1);
        at(t, 610); set_echo(0, 0);
        at(t, 615);
        drained("t2a_drained");

        // Echo high 90..150 straddles the end of blanking: no accept, timeout.
        trigger(0, t);
        expect_ev(0, 1, t + 5003, 600);
        at(t, 90);  set_echo(0, 1);
        at(t, 150); set_echo(0, 0);
        at(t, 5010);
        chk("t2b_busy_after_timeout", bz[0], 0);
        drained("t2b_drained");

        // 2-cycle glitch at 300, real echo at 800.
        trigger(0, t);
        expect_ev(0, 0, t + 806, 800);
        at(t, 300); set_echo(0, 1);
        at(t, 302); set_echo(0, 0);
        at(t, 800); set_echo(0, 1);
        at(t, 810); set_echo(0, 0);
        at(t, 815);
        drained("t3_drained");

        // No echo: timeout, tof_count held at 800.
        trigger(0, t);
        expect_ev(0, 1, t + 5003, 800);
        at(t, 5002);
        chk("t4_test_count_before_timeout", tc[0], 1);
        at(t, 5003);
        chk("t4_test_count_after_timeout", tc[0], 0);
        at(t, 5010);
        drained("t4_drained");

        // Second trigger at 200 -> overrun; echo at 700 keeps the original count.
        trigger(0, t);
        expect_ev(0, 2, t + 203, 800);
        expect_ev(0, 0, t + 706, 700);
        at(t, 200); pt[0] = 1'b1;
        at(t, 220); pt[0] = 1'b0;
        at(t, 700); set_echo(0, 1);
        at(t, 710); set_echo(0, 0);
        at(t, 715);
        drained("t5_drained");

        // Reset at cnt 400: outputs clear at once, no strobes afterwards.
        trigger(0, t);
        at(t, 402);
        RSTn = 1'b0;
        #1;
        chk("t6_rst_test_count", tc[0], 0);
        chk("t6_rst_busy", bz[0], 0);
        chk("t6_rst_tof_count", tofc[0], 0);
        chk("t6_rst_strobes", {vld[0], tmo[0], ovr[0]}, 0);
        step(2);
        RSTn = 1'b1;
        step(5);
        drained("t6_rst_drained");

        // enable low at cnt 400: IDLE next cycle, no strobes, tof_count held.
        trigger(0, t);
        at(t, 402);
        chk("t6_en_busy_before", bz[0], 1);
        en[0] = 1'b0;
        step(1);
        chk("t6_en_busy_after", bz[0], 0);
        chk("t6_en_test_count_after", tc[0], 0);
        en[0] = 1'b1;
        step(10);
        chk("t6_en_tof_count_held", tofc[0], 0);
        drained("t6_en_drained");

        // dut_b: MIN_ECHO=1, 1-cycle active-low echo at 300.
        trigger(1, t);
        expect_ev(1, 0, t + 303, 300);
        at(t, 300); set_echo(1, 1);
        at(t, 301); set_echo(1, 0);
        at(t, 305);
        drained("t3b_drained");

        // dut_b: active-low echo pulled low at 700.
        trigger(1, t);
        expect_ev(1, 0, t + 703, 700);
        at(t, 700); set_echo(1, 1);
        at(t, 710); set_echo(1, 0);
        at(t, 715);
        chk("t6c_tof_count", tofc[1], 700);
        drained("t6c_drained");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, required finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
